// File: rtl/alu_pkg.sv
// Shared opcodes, FSM state type and opcode decode helpers for the bit-serial ALU.
package alu_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b100;
  localparam logic [2:0] OP_XOR = 3'b110;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  // Low for the xor encodings (11x).
  function automatic logic is_arith(input logic [2:0] op);
    return ~(op[1] & op[2]);
  endfunction

  // 001, 011 and 101 all run as subtract.
  function automatic logic is_sub(input logic [2:0] op);
    return op[0] & is_arith(op);
  endfunction

  // Operations that propagate a carry between bits.
  function automatic logic uses_carry(input logic [2:0] op);
    return (op == OP_ADD) | is_sub(op);
  endfunction

endpackage

// File: rtl/alu_serial_ctrl_if.sv
// Request/response bundle between a requester and the bit-serial ALU sequencer.
interface alu_serial_ctrl_if #(parameter int WIDTH = 8);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             carry_out;
  logic             zero_flag;
  logic             busy;

  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, result, carry_out, zero_flag, busy
  );

  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, result, carry_out, zero_flag, busy
  );
endinterface

// File: rtl/alu_serial_slice.sv
// Combinational 1-bit ALU slice: full adder (b inverted for sub) plus bitwise ops.
module alu_serial_slice
  import alu_pkg::*;
(
  input  logic       i_a,
  input  logic       i_b,
  input  logic       i_cin,
  input  logic [2:0] i_op,
  output logic       o_res,
  output logic       o_cout
);
  logic w_sub, w_arith;
  logic w_bx, w_axb, w_sum, w_g, w_p, w_maj;
  logic w_and, w_or, w_xor;

  assign w_sub   = is_sub(i_op);
  assign w_arith = uses_carry(i_op);

  // Full adder on (a, b^sub, cin): carry = a&bx | (a^bx)&cin.
  xor g_bx  (w_bx,  i_b,   w_sub);
  xor g_axb (w_axb, i_a,   w_bx);
  xor g_sum (w_sum, w_axb, i_cin);
  and g_gen (w_g,   i_a,   w_bx);
  and g_prp (w_p,   w_axb, i_cin);
  or  g_maj (w_maj, w_g,   w_p);

  and g_and (w_and, i_a, i_b);
  or  g_or  (w_or,  i_a, i_b);
  xor g_xor (w_xor, i_a, i_b);

  // Result select; logic ops never produce a carry.
  always_comb begin
    o_res  = w_xor;
    o_cout = w_arith & w_maj;
    if (w_arith)             o_res = w_sum;
    else if (i_op == OP_AND) o_res = w_and;
    else if (i_op == OP_OR)  o_res = w_or;
  end
endmodule

// File: rtl/alu_serial_ctrl.sv
// Bit-serial ALU sequencer: latches an operand pair, walks it LSB-first through
// one slice per clock with a registered carry, then presents result and flags.
module alu_serial_ctrl
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic clk,
  input  logic reset_n,
  alu_serial_ctrl_if.slave bus
);
  localparam int CNT_W = $clog2(WIDTH);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_carry;
  logic [2:0]       r_op;
  logic [WIDTH-1:0] r_a, r_b, r_res;
  logic             r_in_ready, r_out_valid, r_busy, r_carry_out, r_zero;

  logic             w_res, w_cout;
  logic [WIDTH-1:0] w_res_next;

  alu_serial_slice u_slice (
    .i_a    (r_a[0]),
    .i_b    (r_b[0]),
    .i_cin  (r_carry),
    .i_op   (r_op),
    .o_res  (w_res),
    .o_cout (w_cout)
  );

  // New result bit enters at the MSB so bit 0 lands at position 0 after WIDTH shifts.
  assign w_res_next = {w_res, r_res[WIDTH-1:1]};

  // Sequencer FSM with registered handshake outputs and flags.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_carry     <= 1'b0;
      r_op        <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_res       <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_carry_out <= 1'b0;
      r_zero      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.in_valid) begin
            r_a        <= bus.a;
            r_b        <= bus.b;
            r_op       <= bus.op;
            r_cnt      <= '0;
            r_carry    <= is_sub(bus.op);  // +1 of two's-complement negate
            r_state    <= SHIFT;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
          end
        end
        SHIFT: begin
          r_a     <= r_a >> 1;
          r_b     <= r_b >> 1;
          r_res   <= w_res_next;
          r_carry <= w_cout;
          r_cnt   <= r_cnt + 1'b1;
          if (r_cnt == CNT_W'(WIDTH-1)) begin
            r_state     <= DONE;
            r_out_valid <= 1'b1;
            r_carry_out <= w_cout;
            r_zero      <= ~|w_res_next;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            r_state     <= IDLE;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.result    = r_res;
  assign bus.carry_out = r_carry_out;
  assign bus.zero_flag = r_zero;
  assign bus.busy      = r_busy;
endmodule

// File: tb/tb_alu_serial_ctrl.sv
// Directed bench for alu_serial_ctrl with a scoreboard of expected results.
module tb_alu_serial_ctrl;
  localparam int W = 8;

  typedef struct {
    logic [W-1:0] r;
    logic         c;
    logic         z;
  } exp_t;

  logic clk, reset_n;
  int   total = 0;
  int   bad   = 0;
  exp_t sb[$];

  alu_serial_ctrl_if #(.WIDTH(W)) bus ();

  alu_serial_ctrl #(.WIDTH(W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Word-level reference: add/sub via integer arithmetic, no-borrow for sub.
  function automatic exp_t model(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t e;
    logic [W:0] s;
    case (o)
      3'b000:                s = {1'b0, x} + {1'b0, y};
      3'b001, 3'b011, 3'b101: begin s[W-1:0] = x - y; s[W] = (x >= y); end
      3'b010:                s = {1'b0, x & y};
      3'b100:                s = {1'b0, x | y};
      default:               s = {1'b0, x ^ y};
    endcase
    e.r = s[W-1:0];
    e.c = s[W];
    e.z = (s[W-1:0] == '0);
    return e;
  endfunction

  // Drive one request; returns at the negedge just after the accept edge.
  task automatic send(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    int n = 0;
    @(negedge clk);
    while (bus.in_ready !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    check("send_ready_timeout", 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1; bus.op = o; bus.a = x; bus.b = y;
    sb.push_back(model(o, x, y));
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("busy_after_accept", 32'(bus.busy), 32'd1);
  endtask

  // Wait for out_valid (bounded), compare against scoreboard, then handshake.
  task automatic recv(input string tag, input int exp_lat);
    int   n = 0;
    exp_t e;
    while (bus.out_valid !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    check({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
    if (bus.out_valid !== 1'b1) return;
    if (exp_lat >= 0) check({tag, "_latency"}, 32'(n), 32'(exp_lat));
    check({tag, "_sb_nonempty"}, 32'(sb.size() > 0), 32'd1);
    if (sb.size() == 0) return;
    e = sb.pop_front();
    check({tag, "_result"}, 32'(bus.result), 32'(e.r));
    check({tag, "_carry"},  32'(bus.carry_out), 32'(e.c));
    check({tag, "_zero"},   32'(bus.zero_flag), 32'(e.z));
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check({tag, "_valid_drop"}, 32'(bus.out_valid), 32'd0);
    check({tag, "_ready_back"}, 32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    logic [2:0]   jop [3];
    logic [W-1:0] ja  [3];
    logic [W-1:0] jb  [3];
    int           j, got, last, saw;
    exp_t         e;

    reset_n = 1'b0;
    bus.in_valid = 1'b1;  // must be ignored while in reset
    bus.op = 3'b000; bus.a = 8'h11; bus.b = 8'h22; bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_in_ready",  32'(bus.in_ready),  32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_busy",      32'(bus.busy),      32'd0);
    check("rst_result",    32'(bus.result),    32'd0);
    check("rst_carry",     32'(bus.carry_out), 32'd0);
    check("rst_zero",      32'(bus.zero_flag), 32'd0);
    reset_n = 1'b1;
    bus.in_valid = 1'b0;

    // Arithmetic corners
    send(3'b000, 8'hFF, 8'h01); recv("add_ff_01", W);
    send(3'b001, 8'h05, 8'h07); recv("sub_05_07", W);
    send(3'b001, 8'h07, 8'h05); recv("sub_07_05", W);
    send(3'b001, 8'h33, 8'h33); recv("sub_eq", W);

    // Logic ops
    send(3'b010, 8'hA5, 8'h0F); recv("and", W);
    send(3'b100, 8'hA5, 8'h0F); recv("or", W);
    send(3'b110, 8'hA5, 8'h0F); recv("xor", W);
    send(3'b110, 8'hA5, 8'hA5); recv("xor_zero", W);

    // Backpressure with stray requests during SHIFT and DONE
    send(3'b000, 8'h3C, 8'h4B);
    bus.in_valid = 1'b1; bus.op = 3'b001; bus.a = 8'hFF; bus.b = 8'hFF;
    repeat (2) @(negedge clk);
    bus.in_valid = 1'b0;
    begin
      int n = 0;
      while (bus.out_valid !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    end
    for (int i = 0; i < 5; i++) begin
      check("bp_hold_valid",  32'(bus.out_valid), 32'd1);
      check("bp_hold_result", 32'(bus.result),    32'(8'h87));
      check("bp_in_ready",    32'(bus.in_ready),  32'd0);
      bus.in_valid = (i == 2);
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    recv("bp", -1);
    saw = 0;
    repeat (W + 2) begin @(negedge clk); saw |= int'(bus.out_valid); end
    check("bp_no_stray_job", 32'(saw), 32'd0);

    // Reset mid-SHIFT aborts the job
    send(3'b000, 8'h80, 8'h90);
    repeat (3) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    check("midrst_in_ready",  32'(bus.in_ready),  32'd1);
    check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    check("midrst_busy",      32'(bus.busy),      32'd0);
    void'(sb.pop_back());
    reset_n = 1'b1;
    saw = 0;
    repeat (W + 2) begin @(negedge clk); saw |= int'(bus.out_valid); end
    check("midrst_no_valid", 32'(saw), 32'd0);
    send(3'b000, 8'h10, 8'h20); recv("post_rst_add", W);

    // Back-to-back with in_valid held, out_ready=1, including opcode aliases
    jop[0] = 3'b111; ja[0] = 8'hA5; jb[0] = 8'h0F;
    jop[1] = 3'b011; ja[1] = 8'h07; jb[1] = 8'h05;
    jop[2] = 3'b000; ja[2] = 8'h12; jb[2] = 8'h34;
    @(negedge clk);
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1; bus.op = jop[0]; bus.a = ja[0]; bus.b = jb[0];
    j = 0; got = 0; last = -1;
    for (int c = 0; c < 80 && got < 3; c++) begin
      if (bus.out_valid === 1'b1) begin
        check("b2b_sb_nonempty", 32'(sb.size() > 0), 32'd1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          check("b2b_result", 32'(bus.result),    32'(e.r));
          check("b2b_carry",  32'(bus.carry_out), 32'(e.c));
          check("b2b_zero",   32'(bus.zero_flag), 32'(e.z));
        end
        if (last >= 0) check("b2b_interval", 32'(c - last), 32'(W + 2));
        last = c;
        got++;
      end
      if (bus.in_ready === 1'b1 && j < 3) begin
        sb.push_back(model(jop[j], ja[j], jb[j]));
        j++;
      end else if (bus.in_ready !== 1'b1) begin
        if (j < 3) begin bus.op = jop[j]; bus.a = ja[j]; bus.b = jb[j]; end
        else bus.in_valid = 1'b0;
      end
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    check("b2b_jobs_done", 32'(got), 32'd3);
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
